// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-port SRAM arbiter: FSM state encoding
// and port indices used by the arbiter and its grant pointer.
package sram_arbiter_pkg;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/sram_arbiter_sram.sv
// Single-port synchronous SRAM with a registered read port. A read updates
// the output register one cycle later; writes and idle cycles leave it alone.
module sram #(
  parameter int unsigned N_ENTRIES  = 1024,
  parameter int unsigned DATA_WIDTH = 256,
  localparam int unsigned AW        = $clog2(N_ENTRIES)
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [N_ENTRIES];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage array and read register; contents are never reset.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester front end for a single-port SRAM. After reset it clears
// every entry to INIT_VALUE, then grants one access per cycle and returns
// read data one cycle later, tagged with the requesting port.
// Optional macro SRAM_ARB_RR_EN: round-robin conflict resolution instead of
// fixed port-0 priority.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned          N_ENTRIES  = 1024,
  parameter int unsigned          DATA_WIDTH = 256,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int unsigned         AW         = $clog2(N_ENTRIES)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  p0_req_i,
  input  logic                  p0_we_i,
  input  logic [AW-1:0]         p0_addr_i,
  input  logic [DATA_WIDTH-1:0] p0_data_i,
  output logic                  p0_gnt_o,
  output logic                  p0_rvalid_o,
  input  logic                  p1_req_i,
  input  logic                  p1_we_i,
  input  logic [AW-1:0]         p1_addr_i,
  input  logic [DATA_WIDTH-1:0] p1_data_i,
  output logic                  p1_gnt_o,
  output logic                  p1_rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  init_done_o
);

  state_e                state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  p0_rvalid_q, p0_rvalid_d;
  logic                  p1_rvalid_q, p1_rvalid_d;
`ifdef SRAM_ARB_RR_EN
  logic                  last_q, last_d;
`endif

  logic                  win;
  logic                  sram_en;
  logic                  sram_we;
  logic [AW-1:0]         sram_addr;
  logic [DATA_WIDTH-1:0] sram_wdata;

  // Next-state, arbitration and SRAM command mux; idle while reset is held.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    p0_rvalid_d = 1'b0;
    p1_rvalid_d = 1'b0;
    p0_gnt_o    = 1'b0;
    p1_gnt_o    = 1'b0;
    win         = PORT0;
    sram_en     = 1'b0;
    sram_we     = 1'b0;
    sram_addr   = '0;
    sram_wdata  = '0;
`ifdef SRAM_ARB_RR_EN
    last_d      = last_q;
`endif
    if (!rst_i) begin
      unique case (state_q)
        S_INIT: begin
          sram_en    = 1'b1;
          sram_we    = 1'b1;
          sram_addr  = cnt_q;
          sram_wdata = INIT_VALUE;
          if (cnt_q == AW'(N_ENTRIES - 1)) begin
            state_d     = S_RUN;
            init_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (p0_req_i && p1_req_i) begin
`ifdef SRAM_ARB_RR_EN
            win = (last_q == PORT1) ? PORT0 : PORT1;
`else
            win = PORT0;
`endif
          end else if (p1_req_i) begin
            win = PORT1;
          end else begin
            win = PORT0;
          end
          if (p0_req_i || p1_req_i) begin
            sram_en = 1'b1;
            if (win == PORT0) begin
              p0_gnt_o    = 1'b1;
              sram_we     = p0_we_i;
              sram_addr   = p0_addr_i;
              sram_wdata  = p0_data_i;
              p0_rvalid_d = !p0_we_i;
            end else begin
              p1_gnt_o    = 1'b1;
              sram_we     = p1_we_i;
              sram_addr   = p1_addr_i;
              sram_wdata  = p1_data_i;
              p1_rvalid_d = !p1_we_i;
            end
`ifdef SRAM_ARB_RR_EN
            last_d = win;
`endif
          end
        end
        default: state_d = S_INIT;
      endcase
    end
  end

  // State, clear counter, done flag, read-valid pulses and grant pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      last_q      <= PORT1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
`ifdef SRAM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign init_done_o = init_done_q;
  assign p0_rvalid_o = p0_rvalid_q;
  assign p1_rvalid_o = p1_rvalid_q;

  sram #(
    .N_ENTRIES  (N_ENTRIES),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sram (
    .clk_i   (clk_i),
    .en_i    (sram_en),
    .we_i    (sram_we),
    .addr_i  (sram_addr),
    .wdata_i (sram_wdata),
    .rdata_o (rdata_o)
  );

endmodule
